// File: rtl/vector_feeder.sv
// Packs DIM serial elements into a flat vector, pulses the adder start, then returns the adder sum on a valid/ready port.
// Optional macro VF_ZERO_PAD_EN: in_last terminates a fill early and zero-pads the remaining lanes.
module vector_feeder #(
    parameter int DIM       = 2,
    parameter int WIDTH     = 16,
    parameter int RES_WIDTH = WIDTH + 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic [DIM*WIDTH-1:0] vector,
    output logic                 vec_start,
    input  logic                 adder_finished,
    input  logic [RES_WIDTH-1:0] adder_sum,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [RES_WIDTH-1:0] result_data,
    output logic [15:0]          vec_count
);

    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {FILL, ISSUE, WAIT, RESULT} state_t;

    state_t               r_state, w_next_state;
    logic [IDX_W-1:0]     r_idx;
    logic [DIM*WIDTH-1:0] r_vector;
    logic [RES_WIDTH-1:0] r_result_data;
    logic [15:0]          r_vec_count;
    logic                 w_accept;
    logic                 w_last_lane;
    logic                 w_fill_done;
    logic                 w_capture;
    logic                 w_handshake;

    assign in_ready     = (r_state == FILL) && !Reset;
    assign vec_start    = (r_state == ISSUE);
    assign result_valid = (r_state == RESULT);
    assign vector       = r_vector;
    assign result_data  = r_result_data;
    assign vec_count    = r_vec_count;

    assign w_accept    = in_valid && in_ready;
    assign w_last_lane = (r_idx == IDX_W'(DIM - 1));
    assign w_capture   = (r_state == WAIT) && adder_finished;
    assign w_handshake = result_valid && result_ready;

`ifdef VF_ZERO_PAD_EN
    assign w_fill_done = w_accept && (w_last_lane || in_last);
`else
    logic w_unused_last;
    assign w_unused_last = in_last;
    assign w_fill_done   = w_accept && w_last_lane;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FILL:    if (w_fill_done) w_next_state = ISSUE;
            ISSUE:   w_next_state = WAIT;
            WAIT:    if (w_capture) w_next_state = RESULT;
            RESULT:  if (w_handshake) w_next_state = FILL;
            default: w_next_state = FILL;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= FILL;
            r_idx         <= '0;
            r_vector      <= '0;
            r_result_data <= '0;
            r_vec_count   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
`ifdef VF_ZERO_PAD_EN
                // Early termination clears every lane above the one just written.
                if (in_last) begin
                    for (int unsigned i = 0; i < DIM; i++) begin
                        if (i > 32'(r_idx)) r_vector[i*WIDTH +: WIDTH] <= '0;
                    end
                end
`endif
                r_vector[r_idx*WIDTH +: WIDTH] <= in_data;
                r_idx <= w_fill_done ? '0 : r_idx + 1'b1;
            end
            if (w_capture) r_result_data <= adder_sum;
            if (w_handshake) begin
                r_vector    <= '0;
                r_vec_count <= r_vec_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vector_feeder.sv
// Directed self-checking bench for vector_feeder: a DIM=2 instance for the main flow and a DIM=4 instance for in_last.
module tb_vector_feeder;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        in_valid, in_last, adder_finished, result_ready;
    logic [15:0] in_data;
    logic [19:0] adder_sum;
    logic        in_ready, vec_start, result_valid;
    logic [31:0] vector;
    logic [19:0] result_data;
    logic [15:0] vec_count;

    logic        in_valid4, in_last4;
    logic [15:0] in_data4;
    logic        in_ready4, vec_start4, result_valid4;
    logic [63:0] vector4;
    logic [19:0] result_data4;
    logic [15:0] vec_count4;

    int n_pass  = 0;
    int n_total = 0;

    always #5 Clock = ~Clock;

    vector_feeder #(.DIM(2), .WIDTH(16), .RES_WIDTH(20)) u_dut (
        .Clock(Clock), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .vector(vector), .vec_start(vec_start),
        .adder_finished(adder_finished), .adder_sum(adder_sum),
        .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
        .vec_count(vec_count)
    );

    vector_feeder #(.DIM(4), .WIDTH(16), .RES_WIDTH(20)) u_dut4 (
        .Clock(Clock), .Reset(Reset),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_last(in_last4),
        .vector(vector4), .vec_start(vec_start4),
        .adder_finished(1'b0), .adder_sum(20'h0),
        .result_valid(result_valid4), .result_ready(1'b0), .result_data(result_data4),
        .vec_count(vec_count4)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        adder_finished = 1'b0; adder_sum = '0; result_ready = 1'b0;
        in_valid4 = 1'b0; in_last4 = 1'b0; in_data4 = '0;
        step(); step();
        n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else n_pass++;
        n_total++; if (vector !== 32'h0) $display("FAIL reset_vector got=%h exp=0", vector); else n_pass++;
        n_total++; if (vec_start !== 1'b0) $display("FAIL reset_vec_start got=%b exp=0", vec_start); else n_pass++;
        n_total++; if (result_valid !== 1'b0) $display("FAIL reset_result_valid got=%b exp=0", result_valid); else n_pass++;
        n_total++; if (result_data !== 20'h0) $display("FAIL reset_result_data got=%h exp=0", result_data); else n_pass++;
        n_total++; if (vec_count !== 16'h0) $display("FAIL reset_vec_count got=%h exp=0", vec_count); else n_pass++;
        Reset = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready got=%b exp=1", in_ready); else n_pass++;
    endtask

    task automatic test_fill_issue();
        in_valid = 1'b1; in_data = 16'h0008;
        step();
        n_total++; if (vec_start !== 1'b0) $display("FAIL fill_no_start_early got=%b exp=0", vec_start); else n_pass++;
        step();
        in_valid = 1'b0;
        n_total++; if (vec_start !== 1'b1) $display("FAIL issue_vec_start got=%b exp=1", vec_start); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL issue_in_ready got=%b exp=0", in_ready); else n_pass++;
        n_total++; if (vector !== 32'h00080008) $display("FAIL issue_vector got=%h exp=00080008", vector); else n_pass++;
        step();
        n_total++; if (vec_start !== 1'b0) $display("FAIL start_one_cycle got=%b exp=0", vec_start); else n_pass++;
    endtask

    task automatic test_wait();
        for (int i = 0; i < 5; i++) begin
            step();
            n_total++; if (vector !== 32'h00080008) $display("FAIL wait_vector_%0d got=%h exp=00080008", i, vector); else n_pass++;
            n_total++; if (result_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL wait_idle_%0d got rv=%b ir=%b exp 0 0", i, result_valid, in_ready); else n_pass++;
        end
        adder_finished = 1'b1; adder_sum = 20'h00010;
        step();
        adder_finished = 1'b0; adder_sum = 20'hFFFFF;
        n_total++; if (result_valid !== 1'b1) $display("FAIL capture_valid got=%b exp=1", result_valid); else n_pass++;
        n_total++; if (result_data !== 20'h00010) $display("FAIL capture_data got=%h exp=00010", result_data); else n_pass++;
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_data = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++; if (result_valid !== 1'b1 || result_data !== 20'h00010) $display("FAIL bp_hold_%0d got rv=%b rd=%h exp 1 00010", i, result_valid, result_data); else n_pass++;
            n_total++; if (in_ready !== 1'b0 || vector !== 32'h00080008) $display("FAIL bp_noaccept_%0d got ir=%b vec=%h exp 0 00080008", i, in_ready, vector); else n_pass++;
        end
        in_valid = 1'b0; result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        n_total++; if (vec_count !== 16'd1) $display("FAIL bp_vec_count got=%0d exp=1", vec_count); else n_pass++;
        n_total++; if (vector !== 32'h0) $display("FAIL bp_vector_clear got=%h exp=0", vector); else n_pass++;
        n_total++; if (result_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_back_to_fill got rv=%b ir=%b exp 0 1", result_valid, in_ready); else n_pass++;
    endtask

    task automatic test_spurious_finished();
        adder_finished = 1'b1; adder_sum = 20'hABCDE;
        step();
        n_total++; if (result_valid !== 1'b0) $display("FAIL spur_fill got=%b exp=0", result_valid); else n_pass++;
        in_valid = 1'b1; in_data = 16'h0001;
        step();
        in_data = 16'h0002;
        step();
        in_valid = 1'b0;
        n_total++; if (vec_start !== 1'b1 || vector !== 32'h00020001) $display("FAIL spur_issue got vs=%b vec=%h exp 1 00020001", vec_start, vector); else n_pass++;
        adder_finished = 1'b0;
        step();
        n_total++; if (result_valid !== 1'b0) $display("FAIL spur_start_cycle got=%b exp=0", result_valid); else n_pass++;
        step();
        n_total++; if (result_valid !== 1'b0) $display("FAIL spur_wait_hold got=%b exp=0", result_valid); else n_pass++;
        adder_finished = 1'b1; adder_sum = 20'h12345;
        step();
        adder_finished = 1'b0;
        n_total++; if (result_valid !== 1'b1 || result_data !== 20'h12345) $display("FAIL spur_capture got rv=%b rd=%h exp 1 12345", result_valid, result_data); else n_pass++;
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        n_total++; if (vec_count !== 16'd2) $display("FAIL spur_vec_count got=%0d exp=2", vec_count); else n_pass++;
    endtask

    task automatic test_reset_abort();
        in_valid = 1'b1; in_data = 16'h1111;
        step();
        in_valid = 1'b0; Reset = 1'b1;
        step();
        Reset = 1'b0;
        n_total++; if (vector !== 32'h0 || vec_count !== 16'h0) $display("FAIL abort_fill got vec=%h cnt=%h exp 0 0", vector, vec_count); else n_pass++;
        in_valid = 1'b1; in_data = 16'h00AA;
        step();
        in_data = 16'h00BB;
        step();
        in_valid = 1'b0;
        step();
        adder_finished = 1'b1; adder_sum = 20'h00165;
        step();
        adder_finished = 1'b0;
        n_total++; if (result_valid !== 1'b1) $display("FAIL abort_pre_result got=%b exp=1", result_valid); else n_pass++;
        Reset = 1'b1;
        step();
        n_total++; if (result_valid !== 1'b0 || result_data !== 20'h0) $display("FAIL abort_result got rv=%b rd=%h exp 0 0", result_valid, result_data); else n_pass++;
        n_total++; if (vector !== 32'h0 || vec_start !== 1'b0 || in_ready !== 1'b0) $display("FAIL abort_outputs got vec=%h vs=%b ir=%b exp 0 0 0", vector, vec_start, in_ready); else n_pass++;
        Reset = 1'b0;
        in_valid = 1'b1; in_data = 16'h0005;
        step();
        in_data = 16'h0006;
        step();
        in_valid = 1'b0;
        n_total++; if (vector !== 32'h00060005 || vec_start !== 1'b1) $display("FAIL abort_refill got vec=%h vs=%b exp 00060005 1", vector, vec_start); else n_pass++;
        step();
        adder_finished = 1'b1; adder_sum = 20'h0000B;
        step();
        adder_finished = 1'b0; result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        n_total++; if (vec_count !== 16'd1) $display("FAIL abort_vec_count got=%0d exp=1", vec_count); else n_pass++;
    endtask

    task automatic test_zero_pad();
        in_valid4 = 1'b1; in_data4 = 16'h0003; in_last4 = 1'b1;
        step();
        in_valid4 = 1'b0; in_last4 = 1'b0;
`ifdef VF_ZERO_PAD_EN
        n_total++; if (vec_start4 !== 1'b1 || in_ready4 !== 1'b0) $display("FAIL pad_issue got vs=%b ir=%b exp 1 0", vec_start4, in_ready4); else n_pass++;
        n_total++; if (vector4 !== 64'h0000_0000_0000_0003) $display("FAIL pad_vector got=%h exp=0000000000000003", vector4); else n_pass++;
        step();
        n_total++; if (vec_start4 !== 1'b0) $display("FAIL pad_start_one_cycle got=%b exp=0", vec_start4); else n_pass++;
`else
        n_total++; if (vec_start4 !== 1'b0 || in_ready4 !== 1'b1) $display("FAIL nopad_stay_fill got vs=%b ir=%b exp 0 1", vec_start4, in_ready4); else n_pass++;
        n_total++; if (vector4 !== 64'h0000_0000_0000_0003) $display("FAIL nopad_lane0 got=%h exp=0000000000000003", vector4); else n_pass++;
        step();
        n_total++; if (vec_start4 !== 1'b0) $display("FAIL nopad_no_start got=%b exp=0", vec_start4); else n_pass++;
        in_valid4 = 1'b1;
        for (int i = 4; i <= 6; i++) begin
            in_data4 = 16'(i);
            step();
        end
        in_valid4 = 1'b0;
        n_total++; if (vec_start4 !== 1'b1 || vector4 !== 64'h0006_0005_0004_0003) $display("FAIL nopad_full got vs=%b vec=%h exp 1 0006000500040003", vec_start4, vector4); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_fill_issue();
        test_wait();
        test_backpressure();
        test_spurious_finished();
        test_reset_abort();
        test_zero_pad();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
